// File: rtl/adc_sample_ctrl.sv
// Sample sequencer for an SPI ADC master: periodic start pulses, capture, 2^AVG_LOG2 averaging.
// Optional overrun detection is compiled in with `define OVERRUN_DETECT_EN.
module adc_sample_ctrl #(
   parameter int SAMPLE_PERIOD = 50000,
   parameter int AVG_LOG2      = 2,
   parameter int TIMEOUT       = 1023
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic       enable,
   input  logic       cs_n,
   input  logic [7:0] adc_data,
   output logic       start,
   output logic [7:0] avg_data,
   output logic       avg_valid,
   output logic       busy,
   output logic       timeout_err,
   output logic       overrun,
   output logic [2:0] o_dbg_state
);

   localparam int PW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
   localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam int AW = 8 + AVG_LOG2;
   localparam int CW = AVG_LOG2 + 1;
   localparam logic [PW-1:0] PLAST = PW'(SAMPLE_PERIOD - 1);
   localparam logic [TW-1:0] TLAST = TW'(TIMEOUT);
   localparam logic [CW-1:0] NAVG  = CW'(1 << AVG_LOG2);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_WAIT_TICK = 3'd1,
      S_START     = 3'd2,
      S_WAIT_LOW  = 3'd3,
      S_WAIT_HIGH = 3'd4,
      S_ACCUM     = 3'd5
   } state_t;

   state_t        r_state;
   logic [PW-1:0] r_per;
   logic [TW-1:0] r_tmo;
   logic [AW-1:0] r_acc;
   logic [CW-1:0] r_cnt;
   logic [7:0]    r_sample;
   logic [7:0]    r_avg_data;
   logic          r_start;
   logic          r_avg_valid;
   logic          r_busy;
   logic          r_timeout_err;
   logic          r_drop;

   logic          w_tick;
   logic          w_enter_idle;
   logic [AW-1:0] w_acc_sum;
   logic [CW-1:0] w_cnt_inc;
   logic [7:0]    w_avg;

   assign w_tick    = enable && (r_per == PLAST);
   assign w_acc_sum = r_acc + AW'(r_sample);
   assign w_cnt_inc = r_cnt + 1'b1;
   // A full sum of 2^AVG_LOG2 bytes shifted down always fits in 8 bits.
   assign w_avg     = w_acc_sum[AW-1:AVG_LOG2];

   // r_drop remembers that enable fell while a frame was in flight.
   assign w_enter_idle = ((r_state == S_WAIT_TICK) && !enable)
                      || ((r_state == S_WAIT_HIGH) && cs_n && (r_drop || !enable))
                      || ((r_state == S_ACCUM) && !enable);

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_per <= '0;
      end else if (!enable || (r_per == PLAST)) begin
         r_per <= '0;
      end else begin
         r_per <= r_per + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_state       <= S_IDLE;
         r_tmo         <= '0;
         r_acc         <= '0;
         r_cnt         <= '0;
         r_sample      <= '0;
         r_avg_data    <= '0;
         r_start       <= 1'b0;
         r_avg_valid   <= 1'b0;
         r_busy        <= 1'b0;
         r_timeout_err <= 1'b0;
         r_drop        <= 1'b0;
      end else begin
         r_start     <= 1'b0;
         r_avg_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (enable) r_state <= S_WAIT_TICK;
            end
            S_WAIT_TICK: begin
               if (enable && w_tick) begin
                  r_state <= S_START;
                  r_start <= 1'b1;
                  r_busy  <= 1'b1;
                  r_drop  <= 1'b0;
               end
            end
            S_START: begin
               r_state <= S_WAIT_LOW;
               r_tmo   <= '0;
               if (!enable) r_drop <= 1'b1;
            end
            S_WAIT_LOW: begin
               if (!enable) r_drop <= 1'b1;
               if (!cs_n) begin
                  r_state <= S_WAIT_HIGH;
                  r_tmo   <= '0;
               end else if (r_tmo == TLAST) begin
                  r_state       <= S_WAIT_TICK;
                  r_busy        <= 1'b0;
                  r_timeout_err <= 1'b1;
                  r_acc         <= '0;
                  r_cnt         <= '0;
                  r_drop        <= 1'b0;
               end else begin
                  r_tmo <= r_tmo + 1'b1;
               end
            end
            S_WAIT_HIGH: begin
               if (!enable) r_drop <= 1'b1;
               if (cs_n) begin
                  r_sample <= adc_data;
                  r_state  <= S_ACCUM;
               end else if (r_tmo == TLAST) begin
                  r_state       <= S_WAIT_TICK;
                  r_busy        <= 1'b0;
                  r_timeout_err <= 1'b1;
                  r_acc         <= '0;
                  r_cnt         <= '0;
                  r_drop        <= 1'b0;
               end else begin
                  r_tmo <= r_tmo + 1'b1;
               end
            end
            S_ACCUM: begin
               if (w_cnt_inc == NAVG) begin
                  r_avg_data  <= w_avg;
                  r_avg_valid <= 1'b1;
                  r_acc       <= '0;
                  r_cnt       <= '0;
               end else begin
                  r_acc <= w_acc_sum;
                  r_cnt <= w_cnt_inc;
               end
               r_state <= S_WAIT_TICK;
               r_busy  <= 1'b0;
            end
            default: r_state <= S_IDLE;
         endcase
         // Entry into IDLE overrides the per-state next values above.
         if (w_enter_idle) begin
            r_state       <= S_IDLE;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b0;
            r_acc         <= '0;
            r_cnt         <= '0;
            r_drop        <= 1'b0;
         end
      end
   end

`ifdef OVERRUN_DETECT_EN
   logic r_overrun;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_overrun <= 1'b0;
      end else if (w_enter_idle) begin
         r_overrun <= 1'b0;
      end else if (w_tick && (r_state != S_WAIT_TICK) && (r_state != S_IDLE)) begin
         r_overrun <= 1'b1;
      end
   end

   assign overrun = r_overrun;
`else
   assign overrun = 1'b0;
`endif

   assign start       = r_start;
   assign avg_data    = r_avg_data;
   assign avg_valid   = r_avg_valid;
   assign busy        = r_busy;
   assign timeout_err = r_timeout_err;
   assign o_dbg_state = r_state;

endmodule
